stream_aligner: RTL and testbench
=================================

STREAM_ALIGNER -- requirements
Module: stream_aligner

Interface
REQ-001 SHALL have parameter PIX_W, default 9, bits per pixel.
REQ-002 SHALL have parameter LANES, default 8, pixels per beat (power of 2, >=2).
REQ-003 SHALL have derived SH_W = $clog2(LANES) for shift width.
REQ-004 clk_draw  in  1  sole clock, all logic on rising edge.
REQ-005 rst_draw_n  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  input beat offered.
REQ-007 in_ready  out  1  input beat accepted when in_valid && in_ready.
REQ-008 in_pixels  in  LANES*PIX_W  input pixels, pixel i at [i*PIX_W +: PIX_W].
REQ-009 in_mask  in  LANES  per-pixel valid bits.
REQ-010 in_shift  in  SH_W  pixel offset, sampled only on the first beat of a span.
REQ-011 in_last  in  1  final beat of a span.
REQ-012 out_valid  out  1  output beat offered.
REQ-013 out_ready  in  1  output beat consumed when out_valid && out_ready.
REQ-014 out_pixels  out  LANES*PIX_W  aligned pixels.
REQ-015 out_mask  out  LANES  aligned valid bits.
REQ-016 out_last  out  1  final output beat of a span.

Function
REQ-017 SHALL implement states IDLE (nothing held), PRIMED (one beat held in hold register), DRAIN (last beat held, tail pending).
REQ-018 Window W = {in beat, hold beat} (2*LANES pixels, hold in low half); aligned beat = pixels sh..sh+LANES-1 of W, mask likewise, sh = latched shift.
REQ-019 IDLE: on accept, latch in_shift into sh, load hold with pixels/mask; go PRIMED, or DRAIN if in_last; no output produced.
REQ-020 PRIMED: on accept, load output register with aligned beat of W, out_last=0, hold <= in beat; go DRAIN if in_last, else stay PRIMED.
REQ-021 DRAIN: in_ready=0; when output register free, load aligned beat of {zero beat with mask 0, hold}, out_last=1; go IDLE.
REQ-022 A span of M input beats SHALL produce exactly M output beats, last one flagged out_last.
REQ-023 Output register: in_ready = (state!=DRAIN) && (!out_valid || out_ready); out_valid set on load, cleared on consume without load; simultaneous consume and load SHALL keep out_valid=1 with new data.
REQ-024 out_pixels/out_mask/out_last SHALL hold stable while out_valid && !out_ready.
REQ-025 Full throughput: with out_ready=1 constantly, one beat accepted per cycle in IDLE/PRIMED; DRAIN costs one cycle per span.
REQ-026 sh=0 SHALL yield out beat = previous input beat unchanged (pure one-beat delay).
REQ-027 in_shift changes mid-span SHALL be ignored; in_pixels/in_mask/in_last ignored when not accepted.

Reset
REQ-028 On clk_draw edge with rst_draw_n=0: state=IDLE, out_valid=0, out_pixels=0, out_mask=0, out_last=0, hold=0, sh=0.
REQ-029 Reset mid-span SHALL discard held and pending beats; in_ready SHALL read 1 the cycle after release.

Configuration
REQ-030 With STREAM_ALIGNER_PIXEL_ZERO_EN defined, each out pixel whose out_mask bit is 0 SHALL be forced to all zeros.
REQ-031 Without STREAM_ALIGNER_PIXEL_ZERO_EN, masked-off pixels SHALL carry window data unmodified (zero-fill only in DRAIN tail).

Verification (LANES=8, PIX_W=9, pixel value = index)
REQ-032 Span of 2 beats, pixels 0..15, masks FF, shift 0, out_ready=1 -> outputs 0..7 then 8..15 (out_last=1), masks FF,FF.
REQ-033 Same span, shift 3 -> outputs 3..10 mask FF, then 11..15,0,0,0 mask 1F out_last=1.
REQ-034 Single-beat span (in_last on first beat), shift 5, mask FF -> one output 5,6,7,0.. mask 07 out_last=1, in_ready low exactly one cycle.
REQ-035 out_ready held 0 for 4 cycles during 3-beat span -> in_ready drops, output stable, no beat lost or duplicated after release.
REQ-036 rst_draw_n low for 1 cycle while in PRIMED -> all outputs 0, next span with shift 2 aligns from fresh state.
REQ-037 Mask 0F on second beat with STREAM_ALIGNER_PIXEL_ZERO_EN, shift 4 -> masked-off output pixels read 0; without macro they read window values.

Source files
------------

// File: rtl/stream_aligner_if.sv
// Stream aligner bus: input beat stream plus aligned output beat stream.
// The slave modport is the aligner's view; the master modport is the view of the block driving it.
interface stream_aligner_if #(
  parameter int PIX_W = 9,
  parameter int LANES = 8
) ();
  localparam int SH_W = $clog2(LANES);

  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*PIX_W-1:0] in_pixels;
  logic [LANES-1:0]       in_mask;
  logic [SH_W-1:0]        in_shift;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*PIX_W-1:0] out_pixels;
  logic [LANES-1:0]       out_mask;
  logic                   out_last;

  modport slave (
    input  in_valid, in_pixels, in_mask, in_shift, in_last, out_ready,
    output in_ready, out_valid, out_pixels, out_mask, out_last
  );

  modport master (
    output in_valid, in_pixels, in_mask, in_shift, in_last, out_ready,
    input  in_ready, out_valid, out_pixels, out_mask, out_last
  );
endinterface

// File: rtl/stream_aligner.sv
// Re-aligns a span of pixel beats by a per-span lane offset, emitting one output beat per input beat.
// Optional STREAM_ALIGNER_PIXEL_ZERO_EN: zero every output pixel whose mask bit is clear.
module stream_aligner #(
  parameter int PIX_W = 9,
  parameter int LANES = 8
) (
  input  logic            clk_draw,
  input  logic            rst_draw_n,
  stream_aligner_if.slave bus
);
  localparam int SH_W   = $clog2(LANES);
  localparam int BEAT_W = LANES * PIX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIMED = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t              r_state;
  logic [BEAT_W-1:0]   r_hold_pix;
  logic [LANES-1:0]    r_hold_mask;
  logic [SH_W-1:0]     r_sh;
  logic                r_out_valid;
  logic [BEAT_W-1:0]   r_out_pix;
  logic [LANES-1:0]    r_out_mask;
  logic                r_out_last;

  logic                w_out_free;
  logic                w_in_ready;
  logic                w_accept;
  logic [BEAT_W-1:0]   w_hi_pix;
  logic [LANES-1:0]    w_hi_mask;
  logic [2*BEAT_W-1:0] w_win_pix;
  logic [2*LANES-1:0]  w_win_mask;
  logic [BEAT_W-1:0]   w_al_pix;
  logic [LANES-1:0]    w_al_mask;

  assign w_out_free = !r_out_valid || bus.out_ready;
  assign w_in_ready = (r_state != DRAIN) && w_out_free;
  assign w_accept   = bus.in_valid && w_in_ready;

  // Upper window half: live input beat, or an empty beat while flushing the tail.
  always_comb begin
    if (r_state == DRAIN) begin
      w_hi_pix  = '0;
      w_hi_mask = '0;
    end else begin
      w_hi_pix  = bus.in_pixels;
      w_hi_mask = bus.in_mask;
    end
  end

  assign w_win_pix  = {w_hi_pix, r_hold_pix};
  assign w_win_mask = {w_hi_mask, r_hold_mask};

  // Lane select: output lane i takes window lane sh+i.
  always_comb begin
    w_al_pix  = '0;
    w_al_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      w_al_mask[i] = w_win_mask[int'(r_sh) + i];
`ifdef STREAM_ALIGNER_PIXEL_ZERO_EN
      if (w_win_mask[int'(r_sh) + i]) begin
        w_al_pix[i*PIX_W +: PIX_W] = w_win_pix[(int'(r_sh) + i)*PIX_W +: PIX_W];
      end else begin
        w_al_pix[i*PIX_W +: PIX_W] = {PIX_W{1'b0}};
      end
`else
      w_al_pix[i*PIX_W +: PIX_W] = w_win_pix[(int'(r_sh) + i)*PIX_W +: PIX_W];
`endif
    end
  end

  // Span FSM with hold register and registered output beat.
  always_ff @(posedge clk_draw) begin
    if (!rst_draw_n) begin
      r_state     <= IDLE;
      r_hold_pix  <= '0;
      r_hold_mask <= '0;
      r_sh        <= '0;
      r_out_valid <= 1'b0;
      r_out_pix   <= '0;
      r_out_mask  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      // A consumed beat retires unless a new load below overrides it.
      if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sh        <= bus.in_shift;
            r_hold_pix  <= bus.in_pixels;
            r_hold_mask <= bus.in_mask;
            r_state     <= bus.in_last ? DRAIN : PRIMED;
          end
        end
        PRIMED: begin
          if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_pix   <= w_al_pix;
            r_out_mask  <= w_al_mask;
            r_out_last  <= 1'b0;
            r_hold_pix  <= bus.in_pixels;
            r_hold_mask <= bus.in_mask;
            r_state     <= bus.in_last ? DRAIN : PRIMED;
          end
        end
        DRAIN: begin
          if (w_out_free) begin
            r_out_valid <= 1'b1;
            r_out_pix   <= w_al_pix;
            r_out_mask  <= w_al_mask;
            r_out_last  <= 1'b1;
            r_hold_pix  <= '0;
            r_hold_mask <= '0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_pixels = r_out_pix;
  assign bus.out_mask   = r_out_mask;
  assign bus.out_last   = r_out_last;
endmodule

// File: tb/tb_stream_aligner.sv
// Directed table-driven bench for stream_aligner (LANES=8, PIX_W=9, pixel value = index).
module tb_stream_aligner;
  localparam int PIX_W = 9;
  localparam int LANES = 8;

  typedef struct {
    logic        rn;
    logic        vld;
    logic [71:0] pix;
    logic [7:0]  msk;
    logic [2:0]  sh;
    logic        lst;
    logic        ordy;
    logic        crdy;
    logic        erdy;
    logic        evld;
    logic        cdat;
    logic [71:0] epix;
    logic [7:0]  emsk;
    logic        elst;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  vec_t tbl[$];
  logic [71:0] z;

  stream_aligner_if #(.PIX_W(PIX_W), .LANES(LANES)) bus ();

  stream_aligner #(.PIX_W(PIX_W), .LANES(LANES)) dut (
    .clk_draw   (clk),
    .rst_draw_n (rst_n),
    .bus        (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pixels start..start+n-1 in lanes 0..n-1, zero in the rest.
  function automatic logic [71:0] s(input int start, input int n);
    logic [71:0] p;
    p = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < n) p[i*PIX_W +: PIX_W] = 9'(start + i);
    end
    return p;
  endfunction

  function automatic vec_t mkv(input logic rn, input logic vld, input logic [71:0] pix,
                               input logic [7:0] msk, input logic [2:0] sh, input logic lst,
                               input logic ordy, input logic crdy, input logic erdy,
                               input logic evld, input logic cdat, input logic [71:0] epix,
                               input logic [7:0] emsk, input logic elst);
    vec_t v;
    v.rn = rn; v.vld = vld; v.pix = pix; v.msk = msk; v.sh = sh; v.lst = lst; v.ordy = ordy;
    v.crdy = crdy; v.erdy = erdy; v.evld = evld; v.cdat = cdat;
    v.epix = epix; v.emsk = emsk; v.elst = elst;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check in_ready before the edge and outputs after it.
  task automatic run(input vec_t v, input int idx);
    @(negedge clk);
    rst_n         = v.rn;
    bus.in_valid  = v.vld;
    bus.in_pixels = v.pix;
    bus.in_mask   = v.msk;
    bus.in_shift  = v.sh;
    bus.in_last   = v.lst;
    bus.out_ready = v.ordy;
    #1;
    if (v.crdy) chk("in_ready", idx, 72'(bus.in_ready), 72'(v.erdy));
    @(posedge clk);
    #1;
    chk("out_valid", idx, 72'(bus.out_valid), 72'(v.evld));
    if (v.cdat) begin
      chk("out_pixels", idx, bus.out_pixels, v.epix);
      chk("out_mask", idx, 72'(bus.out_mask), 72'(v.emsk));
      chk("out_last", idx, 72'(bus.out_last), 72'(v.elst));
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    z = '0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_pixels = '0;
    bus.in_mask = '0;
    bus.in_shift = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    tbl.push_back(mkv(0,0,z,8'h00,0,0,1, 0,0, 0,1, z,8'h00,0));
    // Two-beat span, shift 0: pure one-beat delay
    tbl.push_back(mkv(1,1,s(0,8),8'hFF,0,0,1, 1,1, 0,0, z,8'h00,0));
    tbl.push_back(mkv(1,1,s(8,8),8'hFF,0,1,1, 1,1, 1,1, s(0,8),8'hFF,0));
    tbl.push_back(mkv(1,0,z,8'h00,0,0,1, 1,0, 1,1, s(8,8),8'hFF,1));
    tbl.push_back(mkv(1,0,z,8'h00,0,0,1, 1,1, 0,0, z,8'h00,0));
    // Two-beat span, shift 3; mid-span shift change ignored
    tbl.push_back(mkv(1,1,s(0,8),8'hFF,3,0,1, 1,1, 0,0, z,8'h00,0));
    tbl.push_back(mkv(1,1,s(8,8),8'hFF,6,1,1, 1,1, 1,1, s(3,8),8'hFF,0));
    tbl.push_back(mkv(1,0,z,8'h00,0,0,1, 1,0, 1,1, s(11,5),8'h1F,1));
    tbl.push_back(mkv(1,0,z,8'h00,0,0,1, 1,1, 0,0, z,8'h00,0));
    // Single-beat span, shift 5; offered beat during DRAIN is not accepted
    tbl.push_back(mkv(1,1,s(0,8),8'hFF,5,1,1, 1,1, 0,0, z,8'h00,0));
    tbl.push_back(mkv(1,1,s(40,8),8'hFF,1,0,1, 1,0, 1,1, s(5,3),8'h07,1));
    tbl.push_back(mkv(1,0,z,8'h00,0,0,1, 1,1, 0,0, z,8'h00,0));
    // Partial mask 0F on second beat, shift 4
    tbl.push_back(mkv(1,1,s(0,8),8'hFF,4,0,1, 1,1, 0,0, z,8'h00,0));
    tbl.push_back(mkv(1,1,s(8,8),8'h0F,4,1,1, 1,1, 1,1, s(4,8),8'hFF,0));
`ifdef STREAM_ALIGNER_PIXEL_ZERO_EN
    tbl.push_back(mkv(1,0,z,8'h00,0,0,1, 1,0, 1,1, z,8'h00,1));
`else
    tbl.push_back(mkv(1,0,z,8'h00,0,0,1, 1,0, 1,1, s(12,4),8'h00,1));
`endif
    tbl.push_back(mkv(1,0,z,8'h00,0,0,1, 1,1, 0,0, z,8'h00,0));
    // Partial mask 0F on second beat, shift 2: tail mixes kept and masked lanes
    tbl.push_back(mkv(1,1,s(0,8),8'hFF,2,0,1, 1,1, 0,0, z,8'h00,0));
    tbl.push_back(mkv(1,1,s(8,8),8'h0F,2,1,1, 1,1, 1,1, s(2,8),8'hFF,0));
`ifdef STREAM_ALIGNER_PIXEL_ZERO_EN
    tbl.push_back(mkv(1,0,z,8'h00,0,0,1, 1,0, 1,1, s(10,2),8'h03,1));
`else
    tbl.push_back(mkv(1,0,z,8'h00,0,0,1, 1,0, 1,1, s(10,6),8'h03,1));
`endif
    tbl.push_back(mkv(1,0,z,8'h00,0,0,1, 1,1, 0,0, z,8'h00,0));

    for (int i = 0; i < tbl.size(); i++) begin
      run(tbl[i], i);
    end

    // Backpressure: out_ready low 4 cycles in a 3-beat span, shift 1
    run(mkv(1,1,s(0,8),8'hFF,1,0,1, 1,1, 0,0, z,8'h00,0), 100);
    run(mkv(1,1,s(8,8),8'hFF,7,0,0, 1,1, 1,1, s(1,8),8'hFF,0), 101);
    run(mkv(1,1,s(16,8),8'hFF,7,1,0, 1,0, 1,1, s(1,8),8'hFF,0), 102);
    run(mkv(1,1,s(16,8),8'hFF,7,1,0, 1,0, 1,1, s(1,8),8'hFF,0), 103);
    run(mkv(1,1,s(16,8),8'hFF,7,1,0, 1,0, 1,1, s(1,8),8'hFF,0), 104);
    run(mkv(1,1,s(16,8),8'hFF,7,1,1, 1,1, 1,1, s(9,8),8'hFF,0), 105);
    run(mkv(1,0,z,8'h00,0,0,1, 1,0, 1,1, s(17,7),8'h7F,1), 106);
    run(mkv(1,0,z,8'h00,0,0,1, 1,1, 0,0, z,8'h00,0), 107);

    // Reset while PRIMED with an output pending, then a fresh span with shift 2
    run(mkv(1,1,s(0,8),8'hFF,3,0,1, 1,1, 0,0, z,8'h00,0), 200);
    run(mkv(1,1,s(8,8),8'hFF,3,0,0, 1,1, 1,1, s(3,8),8'hFF,0), 201);
    run(mkv(0,1,s(16,8),8'hFF,3,0,0, 0,0, 0,1, z,8'h00,0), 202);
    run(mkv(1,1,s(32,8),8'hFF,2,0,1, 1,1, 0,0, z,8'h00,0), 203);
    run(mkv(1,1,s(40,8),8'hFF,5,1,1, 1,1, 1,1, s(34,8),8'hFF,0), 204);
    run(mkv(1,0,z,8'h00,0,0,1, 1,0, 1,1, s(42,6),8'h3F,1), 205);
    run(mkv(1,0,z,8'h00,0,0,1, 1,1, 0,0, z,8'h00,0), 206);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
